periph_bus_ctrl: RTL and testbench

Parametrised peripheral bus controller that sits between the MIPS core's data-memory port and the memory-mapped peripherals (port I/O, timer, PIC, and later slots). It decodes the peripheral address window into a registered one-hot chip-select across `N_PERIPH` channels and forwards the register offset and write data. It waits for a per-channel ready handshake and returns read data, a ready pulse, and a bus-error flag. Unmapped or timed-out accesses complete with an error rather than hanging the core.

---
 rtl/periph_bus_pkg.sv | 18 +
 rtl/periph_addr_decode.sv | 39 +++
 rtl/periph_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_periph_bus_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus controller and its address decoder.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_e;

  localparam int SLOT_PORT_IO     = 0;
  localparam int SLOT_TIMER       = 1;
  localparam int SLOT_PIC         = 2;
  localparam int SLOT_PCTRL       = 3;
  localparam int PERIPH_SPACE_BIT = 31;
  localparam int CNT_W            = 8;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational decode of a core byte address into peripheral-space hit, mapped flag,
// one-hot channel select and register offset.
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int N_PERIPH = 4,
  parameter int SLOT_LSB = 8,
  parameter int SLOT_W   = 4,
  parameter int REG_W    = 6
) (
  input  logic [31:0]         i_addr,
  output logic                o_periph,
  output logic                o_mapped,
  output logic [N_PERIPH-1:0] o_sel,
  output logic [REG_W-1:0]    o_reg_addr
);

  localparam int HI_LSB = SLOT_LSB + SLOT_W;

  logic [SLOT_W-1:0] w_slot;
  logic              w_hi_zero;
  logic              w_aligned;
  logic              w_in_range;

  assign w_slot     = i_addr[HI_LSB-1:SLOT_LSB];
  // Everything between the slot field and the space bit must be clear to alias nothing.
  assign w_hi_zero  = ((i_addr[30:0] >> HI_LSB) == 31'd0);
  assign w_aligned  = (i_addr[1:0] == 2'b00);
  assign w_in_range = (int'(w_slot) < N_PERIPH);

  assign o_periph   = i_addr[PERIPH_SPACE_BIT];
  assign o_mapped   = o_periph & w_in_range & w_hi_zero & w_aligned;
  assign o_reg_addr = i_addr[REG_W+1:2];

  for (genvar k = 0; k < N_PERIPH; k++) begin : g_sel
    assign o_sel[k] = (int'(w_slot) == k);
  end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: registered one-hot select, ready handshake with timeout,
// and error completion for unmapped accesses.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int N_PERIPH = 4,
  parameter int SLOT_LSB = 8,
  parameter int SLOT_W   = 4,
  parameter int REG_W    = 6,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_ce,
  input  logic                  cpu_rw,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [N_PERIPH-1:0]   ce_out,
  output logic                  rw_out,
  output logic [REG_W-1:0]      reg_addr,
  output logic [31:0]           wdata_out,
  input  logic [N_PERIPH-1:0]   periph_ready,
  input  logic [32*N_PERIPH-1:0] periph_rdata
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_PERIPH-1:0] r_ce;
  logic                r_rw;
  logic [REG_W-1:0]    r_reg;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_err;

  logic                w_periph;
  logic                w_mapped;
  logic [N_PERIPH-1:0] w_sel;
  logic [REG_W-1:0]    w_reg;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;

  periph_addr_decode #(
    .N_PERIPH (N_PERIPH),
    .SLOT_LSB (SLOT_LSB),
    .SLOT_W   (SLOT_W),
    .REG_W    (REG_W)
  ) u_dec (
    .i_addr     (cpu_addr),
    .o_periph   (w_periph),
    .o_mapped   (w_mapped),
    .o_sel      (w_sel),
    .o_reg_addr (w_reg)
  );

  // The latched one-hot select masks off ready/data from every other channel.
  assign w_sel_ready = |(periph_ready & r_ce);

  always_comb begin
    w_sel_rdata = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      if (r_ce[k]) w_sel_rdata = w_sel_rdata | periph_rdata[32*k +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ce    <= '0;
      r_rw    <= 1'b0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_ce && w_periph) begin
            if (w_mapped) begin
              r_state <= ACCESS;
              r_ce    <= w_sel;
              r_rw    <= cpu_rw;
              r_reg   <= w_reg;
              r_wdata <= cpu_wdata;
              r_cnt   <= '0;
            end else begin
              r_state <= ERROR;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          // Ready is checked before the timeout so a late ready still completes cleanly.
          if (w_sel_ready) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_rdata <= r_rw ? 32'd0 : w_sel_rdata;
            r_ce    <= '0;
          end else if (r_cnt == TO_CNT) begin
            r_state <= ERROR;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_ce    <= '0;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ERROR:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign cpu_err   = r_err;
  assign ce_out    = r_ce;
  assign rw_out    = r_rw;
  assign reg_addr  = r_reg;
  assign wdata_out = r_wdata;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed plus randomized bench for periph_bus_ctrl against a transaction-level model.
module tb_periph_bus_ctrl;

  localparam int NP = 4;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_ce;
  logic          cpu_rw;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic [NP-1:0] ce_out;
  logic          rw_out;
  logic [5:0]    reg_addr;
  logic [31:0]   wdata_out;
  logic [NP-1:0] periph_ready;
  logic [32*NP-1:0] periph_rdata;

  int npass = 0;
  int ntot  = 0;

  logic [31:0] chan [NP];
  logic        last_rw;
  logic [5:0]  last_reg;
  logic [31:0] last_wd;

  periph_bus_ctrl #(
    .N_PERIPH (NP),
    .SLOT_LSB (8),
    .SLOT_W   (4),
    .REG_W    (6),
    .TIMEOUT  (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_ce       (cpu_ce),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .cpu_err      (cpu_err),
    .ce_out       (ce_out),
    .rw_out       (rw_out),
    .reg_addr     (reg_addr),
    .wdata_out    (wdata_out),
    .periph_ready (periph_ready),
    .periph_rdata (periph_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_chan();
    for (int k = 0; k < NP; k++) begin
      chan[k] = $urandom;
      periph_rdata[32*k +: 32] = chan[k];
    end
  endtask

  // One access from request to the cycle after completion; delay = ACCESS cycles before ready.
  task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                         input int delay);
    int          kind, slot, rg, ncyc, exp_cyc;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic        exp_err;
    slot = int'((addr >> 8) & 32'hF);
    rg   = int'((addr >> 2) & 32'h3F);
    if (addr[31] == 1'b0) kind = 0;
    else if (slot < NP && ((addr >> 12) & 32'h7FFFF) == 0 && (addr & 32'h3) == 0) kind = 2;
    else kind = 1;
    load_chan();
    cpu_ce = 1'b1; cpu_addr = addr; cpu_rw = rw; cpu_wdata = wd; periph_ready = '0;
    @(negedge clock);
    if (kind == 0) begin
      cpu_ce = 1'b0;
      chk("ignored_ready", 32'(cpu_ready), 32'd0);
      chk("ignored_ce", 32'(ce_out), 32'd0);
      chk("ignored_rw", 32'(rw_out), 32'(last_rw));
      chk("ignored_reg", 32'(reg_addr), 32'(last_reg));
      chk("ignored_wd", wdata_out, last_wd);
      @(negedge clock);
      chk("ignored_ready2", 32'(cpu_ready), 32'd0);
      return;
    end
    if (kind == 1) begin
      cpu_ce = 1'b0;
      chk("unmapped_ready", 32'(cpu_ready), 32'd1);
      chk("unmapped_err", 32'(cpu_err), 32'd1);
      chk("unmapped_rdata", cpu_rdata, 32'd0);
      chk("unmapped_ce", 32'(ce_out), 32'd0);
      @(negedge clock);
      chk("unmapped_pulse_end", 32'(cpu_ready), 32'd0);
      return;
    end
    sel = 4'(1 << slot);
    chk("rw_out", 32'(rw_out), 32'(rw));
    chk("reg_addr", 32'(reg_addr), 32'(rg));
    chk("wdata_out", wdata_out, wd);
    last_rw = rw; last_reg = 6'(rg); last_wd = wd;
    ncyc = 0;
    // Core keeps ce high with garbage address/data; none of it may be resampled.
    while (ce_out != '0 && ncyc < 40) begin
      chk("ce_onehot", 32'(ce_out), 32'(sel));
      cpu_addr = $urandom; cpu_wdata = $urandom;
      periph_ready = (4'($urandom) & ~sel) | ((ncyc == delay) ? sel : 4'd0);
      ncyc++;
      @(negedge clock);
    end
    cpu_ce = 1'b0; periph_ready = '0;
    exp_err = (delay > TO);
    exp_cyc = exp_err ? TO + 1 : delay + 1;
    exp_rd  = (exp_err || rw) ? 32'd0 : chan[slot];
    chk("ce_cycles", 32'(ncyc), 32'(exp_cyc));
    chk("done_ready", 32'(cpu_ready), 32'd1);
    chk("done_err", 32'(cpu_err), 32'(exp_err));
    chk("done_rdata", cpu_rdata, exp_rd);
    @(negedge clock);
    chk("pulse_end", 32'(cpu_ready), 32'd0);
    chk("idle_ce", 32'(ce_out), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          sl, kind;
    reset = 1'b1; cpu_ce = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    periph_ready = '0; periph_rdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_ce", 32'(ce_out), 32'd0);
    chk("rst_rw", 32'(rw_out), 32'd0);
    chk("rst_reg", 32'(reg_addr), 32'd0);
    chk("rst_wd", wdata_out, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    last_rw = 1'b0; last_reg = '0; last_wd = '0;
    reset = 1'b0;
    @(negedge clock);

    run_txn(32'h8000_0104, 1'b0, 32'h0, 0);
    run_txn(32'h8000_0208, 1'b1, 32'h1234_5678, 3);
    run_txn(32'h8000_0500, 1'b0, 32'h0, 0);
    run_txn(32'h8000_0102, 1'b0, 32'h0, 0);
    run_txn(32'h8000_0000, 1'b0, 32'h0, 1000);
    run_txn(32'h8000_0000, 1'b0, 32'h0, TO);
    run_txn(32'h0000_0104, 1'b1, 32'hCAFE_F00D, 0);

    // Back-to-back with ce held high across the ready pulse.
    load_chan();
    cpu_ce = 1'b1; cpu_addr = 32'h8000_0104; cpu_rw = 1'b0; cpu_wdata = 32'h0;
    periph_ready = 4'b0010;
    @(negedge clock);
    chk("b2b_ce1", 32'(ce_out), 32'h2);
    @(negedge clock);
    chk("b2b_ready1", 32'(cpu_ready), 32'd1);
    chk("b2b_rdata1", cpu_rdata, chan[1]);
    @(negedge clock);
    chk("b2b_idle_ready", 32'(cpu_ready), 32'd0);
    chk("b2b_idle_ce", 32'(ce_out), 32'd0);
    @(negedge clock);
    chk("b2b_ce2", 32'(ce_out), 32'h2);
    cpu_ce = 1'b0;
    @(negedge clock);
    chk("b2b_ready2", 32'(cpu_ready), 32'd1);
    periph_ready = '0;
    @(negedge clock);
    chk("b2b_pulse_end", 32'(cpu_ready), 32'd0);
    last_rw = 1'b0; last_reg = 6'd1; last_wd = 32'h0;

    // Reset in the middle of ACCESS.
    cpu_ce = 1'b1; cpu_addr = 32'h8000_0000; cpu_rw = 1'b1; cpu_wdata = 32'h5555_AAAA;
    @(negedge clock);
    cpu_ce = 1'b0;
    chk("rstmid_ce_before", 32'(ce_out), 32'h1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_ce_async", 32'(ce_out), 32'd0);
    chk("rstmid_ready", 32'(cpu_ready), 32'd0);
    @(negedge clock);
    chk("rstmid_ready2", 32'(cpu_ready), 32'd0);
    reset = 1'b0;
    last_rw = 1'b0; last_reg = '0; last_wd = '0;
    @(negedge clock);
    chk("rstmid_no_pulse", 32'(cpu_ready), 32'd0);
    run_txn(32'h8000_0310, 1'b0, 32'h0, 2);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sl   = int'($urandom_range(0, 5));
      a    = 32'h8000_0000 | (32'(sl) << 8) | (32'($urandom_range(0, 63)) << 2);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      else if (kind == 1) a = a | (32'd1 << $urandom_range(12, 30));
      else if (kind == 2) a = a & 32'h7FFF_FFFF;
      run_txn(a, 1'($urandom), $urandom,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                         : int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
